fetch_stage: RTL and testbench

Instruction-fetch stage including the IF/ID boundary register.
- Holds the PC and drives a req/ack instruction-memory port.
- Presents the fetched instruction, its address and its rd field to decode (Controller, Reg, ImmGen) and onward to IDEX (AddrIn, rdIn).
- Supports a hazard stall, branch/jump redirect, and variable memory latency, including discard of in-flight fetches after a redirect.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DISCARD
  } fetch_state_e;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, one-entry skid buffer for stalls
// and discard of an in-flight request after a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clkIn,
  input  logic            resetIn,
  input  logic            stallIn,
  input  logic            redirectIn,
  input  logic [XLEN-1:0] redirectAddrIn,
  output logic            imemReqOut,
  output logic [XLEN-1:0] imemAddrOut,
  input  logic            imemAckIn,
  input  logic [XLEN-1:0] imemDataIn,
  output logic [XLEN-1:0] instOut,
  output logic [XLEN-1:0] addrOut,
  output logic [4:0]      rdOut,
  output logic            validOut
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] iaddr_q, iaddr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;

  logic            ack_ok;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_pc;

  // An ack is only meaningful while a request is actually on the bus.
  assign ack_ok      = imemAckIn & req_q;
  assign pc_inc      = pc_q + XLEN'(4);
  assign redirect_pc = word_align(redirectAddrIn);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    imem_addr_d = imem_addr_q;
    inst_d      = inst_q;
    iaddr_d     = iaddr_q;
    valid_d     = valid_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;

    if (redirectIn) begin
      inst_d  = NOP_INST;
      iaddr_d = '0;
      valid_d = 1'b0;
      pc_d    = redirect_pc;
      unique case (state_q)
        ST_FETCH, ST_DISCARD: begin
          if (ack_ok) begin
            state_d     = ST_FETCH;
            req_d       = 1'b1;
            imem_addr_d = redirect_pc;
          end else begin
            // Request still outstanding: keep address and req stable.
            state_d = ST_DISCARD;
          end
        end
        default: begin
          state_d     = ST_FETCH;
          req_d       = 1'b1;
          imem_addr_d = redirect_pc;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_FETCH;
          req_d       = 1'b1;
          imem_addr_d = pc_q;
        end
        ST_FETCH: begin
          if (ack_ok && !stallIn) begin
            inst_d      = imemDataIn;
            iaddr_d     = pc_q;
            valid_d     = 1'b1;
            pc_d        = pc_inc;
            imem_addr_d = pc_inc;
          end else if (ack_ok) begin
            skid_data_d = imemDataIn;
            skid_pc_d   = pc_q;
            req_d       = 1'b0;
            state_d     = ST_HOLD;
          end else if (!stallIn) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stallIn) begin
            inst_d      = skid_data_q;
            iaddr_d     = skid_pc_q;
            valid_d     = 1'b1;
            pc_d        = pc_inc;
            req_d       = 1'b1;
            imem_addr_d = pc_inc;
            state_d     = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (ack_ok) begin
            imem_addr_d = pc_q;
            state_d     = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      imem_addr_q <= RESET_PC;
      inst_q      <= NOP_INST;
      iaddr_q     <= '0;
      valid_q     <= 1'b0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      imem_addr_q <= imem_addr_d;
      inst_q      <= inst_d;
      iaddr_q     <= iaddr_d;
      valid_q     <= valid_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign imemReqOut  = req_q;
  assign imemAddrOut = imem_addr_q;
  assign instOut     = inst_q;
  assign addrOut     = iaddr_q;
  assign rdOut       = inst_q[RD_MSB:RD_LSB];
  assign validOut    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clkIn = 1'b0;
  logic        resetIn = 1'b1;
  logic        stallIn = 1'b0;
  logic        redirectIn = 1'b0;
  logic [31:0] redirectAddrIn = '0;
  logic        imemReqOut;
  logic [31:0] imemAddrOut;
  logic        imemAckIn = 1'b0;
  logic [31:0] imemDataIn = '0;
  logic [31:0] instOut;
  logic [31:0] addrOut;
  logic [4:0]  rdOut;
  logic        validOut;

  fetch_stage dut (
    .clkIn(clkIn), .resetIn(resetIn), .stallIn(stallIn),
    .redirectIn(redirectIn), .redirectAddrIn(redirectAddrIn),
    .imemReqOut(imemReqOut), .imemAddrOut(imemAddrOut),
    .imemAckIn(imemAckIn), .imemDataIn(imemDataIn),
    .instOut(instOut), .addrOut(addrOut), .rdOut(rdOut), .validOut(validOut)
  );

  always #5 clkIn = ~clkIn;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  bit log_en = 1;

  // Model: next-cycle expected outputs (m_*) and the currently expected ones (exp_*).
  logic [31:0] m_pc = '0, m_addr = '0, m_inst = NOP, m_iaddr = '0;
  logic        m_req = 0, m_valid = 0;
  bit          started = 0, dropping = 0;
  logic [63:0] skid[$];
  logic [31:0] exp_addr, exp_inst, exp_iaddr;
  logic        exp_req, exp_valid;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic rdr,
                            input logic [31:0] ra, input logic ack, input logic [31:0] data);
    logic [31:0] npc;
    npc = {ra[31:2], 2'b00};
    if (rst) begin
      m_pc = 32'h0; m_req = 0; m_addr = 32'h0;
      m_inst = NOP; m_iaddr = 32'h0; m_valid = 0;
      started = 0; dropping = 0; skid.delete();
    end else if (rdr) begin
      m_valid = 0; m_inst = NOP; m_iaddr = 32'h0;
      if (!started) begin
        started = 1; m_req = 1; m_addr = npc;
      end else if (skid.size() > 0) begin
        skid.delete(); m_req = 1; m_addr = npc;
      end else if (ack) begin
        dropping = 0; m_req = 1; m_addr = npc;
      end else begin
        dropping = 1;
      end
      m_pc = npc;
    end else if (!started) begin
      started = 1; m_req = 1; m_addr = m_pc;
    end else if (skid.size() > 0) begin
      if (!st) begin
        {m_iaddr, m_inst} = skid.pop_front();
        m_valid = 1; m_pc = m_pc + 4; m_req = 1; m_addr = m_pc;
      end
    end else if (dropping) begin
      if (ack) begin
        dropping = 0; m_addr = m_pc;
      end
    end else if (ack && !st) begin
      m_inst = data; m_iaddr = m_pc; m_valid = 1;
      m_pc = m_pc + 4; m_addr = m_pc;
    end else if (ack) begin
      skid.push_back({m_pc, data}); m_req = 0;
    end else if (!st) begin
      m_valid = 0; m_inst = NOP;
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic rdr,
                       input logic [31:0] ra, input logic ack);
    resetIn = rst; stallIn = st; redirectIn = rdr; redirectAddrIn = ra;
    imemAckIn = ack; imemDataIn = memword(imemAddrOut);
    model_step(rst, st, rdr, ra, ack & m_req, imemDataIn);
    @(posedge clkIn); #1;
    exp_req = m_req; exp_addr = m_addr; exp_inst = m_inst;
    exp_iaddr = m_iaddr; exp_valid = m_valid;
    chk_en = 1;
  endtask

  task automatic cyc(input logic st, input logic rdr, input logic [31:0] ra, input logic ack);
    cycle(1'b0, st, rdr, ra, ack);
  endtask

  always @(negedge clkIn) begin
    if (chk_en) begin
      chk("req", {31'b0, imemReqOut}, {31'b0, exp_req});
      chk("imem_addr", imemAddrOut, exp_addr);
      chk("inst", instOut, exp_inst);
      chk("addr", addrOut, exp_iaddr);
      chk("rd", {27'b0, rdOut}, {27'b0, exp_inst[11:7]});
      chk("valid", {31'b0, validOut}, {31'b0, exp_valid});
      if (log_en && validOut)
        $display("txn t=%0t addr=%h inst=%h rd=%0d", $time, addrOut, instOut, rdOut);
    end
  end

  int busy = 0, lat = 0, cnt = 0;

  initial begin
    // Zero-wait memory: sequential addresses, valid from cycle 2.
    cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0);
    chk("rst_req", {31'b0, imemReqOut}, 32'h0);
    chk("rst_imem_addr", imemAddrOut, 32'h0);
    chk("rst_inst", instOut, NOP);
    chk("rst_valid", {31'b0, validOut}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("idle_req", {31'b0, imemReqOut}, 32'h1);
    chk("idle_valid", {31'b0, validOut}, 32'h0);
    cyc(0, 0, 0, 1); chk("zw_addr0", addrOut, 32'h0); chk("zw_valid", {31'b0, validOut}, 32'h1);
    cyc(0, 0, 0, 1); chk("zw_addr4", addrOut, 32'h4);
    cyc(0, 0, 0, 1); chk("zw_addr8", addrOut, 32'h8);
    cyc(0, 0, 0, 1); chk("zw_addr12", addrOut, 32'hC);

    // Slow memory: bubbles then the first word.
    cycle(1, 0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); chk("slow_bubble1", {31'b0, validOut}, 32'h0);
    cyc(0, 0, 0, 0); chk("slow_bubble2", {31'b0, validOut}, 32'h0);
    cyc(0, 0, 0, 1);
    chk("slow_inst", instOut, 32'h00A0_0093);
    chk("slow_rd", {27'b0, rdOut}, 32'h1);
    chk("slow_addr", addrOut, 32'h0);

    // Stall coinciding with the ack at 0x8, late ack during hold is ignored.
    cycle(1, 0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("stall_hold_addr", addrOut, 32'h4);
    chk("stall_req", {31'b0, imemReqOut}, 32'h0);
    cyc(1, 0, 0, 1); chk("hold_addr_a", addrOut, 32'h4); chk("hold_req", {31'b0, imemReqOut}, 32'h0);
    cyc(1, 0, 0, 0); chk("hold_addr_b", addrOut, 32'h4);
    cyc(0, 0, 0, 0);
    chk("release_addr", addrOut, 32'h8);
    chk("release_inst", instOut, memword(32'h8));
    chk("release_next", imemAddrOut, 32'hC);

    // Redirect while the request to 0x10 is outstanding.
    cyc(0, 0, 0, 1); chk("pre_redir_req", imemAddrOut, 32'h10);
    cyc(0, 1, 32'h100, 0);
    chk("redir_valid", {31'b0, validOut}, 32'h0);
    chk("discard_addr", imemAddrOut, 32'h10);
    cyc(0, 0, 0, 0); chk("discard_addr2", imemAddrOut, 32'h10);
    cyc(0, 0, 0, 1);
    chk("discard_drop", {31'b0, validOut}, 32'h0);
    chk("discard_new", imemAddrOut, 32'h100);
    cyc(0, 0, 0, 1); chk("redir_first", addrOut, 32'h100);

    // Redirect beats stall; target is word-aligned.
    cyc(1, 1, 32'h203, 1);
    chk("rs_valid", {31'b0, validOut}, 32'h0);
    chk("rs_inst", instOut, NOP);
    chk("rs_next", imemAddrOut, 32'h200);

    // PC wrap-around.
    cyc(0, 1, 32'hFFFF_FFFE, 1); chk("wrap_req", imemAddrOut, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("wrap_addr", addrOut, 32'hFFFF_FFFC);
    chk("wrap_next", imemAddrOut, 32'h0);

    // Reset mid-fetch and mid-hold; late acks ignored.
    cyc(0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    chk("rf_req", {31'b0, imemReqOut}, 32'h0);
    chk("rf_addr", addrOut, 32'h0);
    chk("rf_valid", {31'b0, validOut}, 32'h0);
    cyc(0, 0, 0, 1); chk("rf_idle_valid", {31'b0, validOut}, 32'h0);
    cyc(1, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    chk("rh_req", {31'b0, imemReqOut}, 32'h0);
    chk("rh_inst", instOut, NOP);
    cyc(0, 0, 0, 1);
    chk("rh_late_ack_req", {31'b0, imemReqOut}, 32'h1);
    chk("rh_late_ack_valid", {31'b0, validOut}, 32'h0);

    // Randomized traffic with variable latency against the model.
    log_en = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, s, d, a;
      logic [31:0] ra;
      r  = ($urandom_range(99) == 0);
      s  = ($urandom_range(3) == 0);
      d  = ($urandom_range(19) == 0);
      ra = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if (imemReqOut) begin
        if (busy == 0) begin
          busy = 1; lat = $urandom_range(3); cnt = 0;
        end
        a = (cnt == lat);
        cnt++;
        if (a) busy = 0;
      end else begin
        busy = 0;
        a = ($urandom_range(9) == 0);
      end
      cycle(r, s, d, ra, a);
    end
    @(negedge clkIn); #1;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
